wavelet_synthesis: RTL and testbench



---
 rtl/wavelet_pkg.sv | 37 +++
 rtl/wavelet_synthesis_if.sv | 35 +++
 rtl/wavelet_saturate.sv | 32 +++
 rtl/wavelet_synthesis.sv | 124 ++++++++++++
 tb/tb_wavelet_synthesis.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wavelet_pkg.sv
// rtl/wavelet_pkg.sv - shared types and width helpers for the wavelet synthesis block
// Purpose: FSM state enum, clog2 helper, unity-gain constant and accumulator width derivation.
// Ports: none (package).
package wavelet_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } state_t;

  localparam int DEF_BITS_PER_ELEM = 8;
  localparam int DEF_NUM_FILTERS   = 8;
  localparam int DEF_GAIN_BITS     = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // Index width that stays legal even for a single-band bank.
  function automatic int addr_bits(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  // Q1.(GAIN_BITS-1) representation of 1.0.
  function automatic int unity_gain(input int gain_bits);
    return 1 << (gain_bits - 1);
  endfunction

  // Product width plus one growth bit per doubling of the band count.
  function automatic int acc_bits(input int bpe, input int gain_bits, input int nf);
    return bpe + gain_bits + 1 + clog2(nf);
  endfunction

endpackage

// File: rtl/wavelet_synthesis_if.sv
// rtl/wavelet_synthesis_if.sv - coefficient, gain and sample signals of wavelet_synthesis
// Purpose: bundles the coefficient stream, gain write port and output sample handshake.
// Modports: slave (the synthesis block), master (the driving side).
interface wavelet_synthesis_if #(
  parameter int BITS_PER_ELEM = 8,
  parameter int NUM_FILTERS   = 8,
  parameter int GAIN_BITS     = 8
);
  import wavelet_pkg::*;

  localparam int ADDR_W = addr_bits(NUM_FILTERS);

  logic signed [BITS_PER_ELEM-1:0] i_coef;
  logic                            i_coef_valid;
  logic                            i_coef_last;
  logic                            o_coef_ready;
  logic                            i_gain_we;
  logic [ADDR_W-1:0]               i_gain_addr;
  logic [GAIN_BITS-1:0]            i_gain_data;
  logic signed [BITS_PER_ELEM-1:0] o_value;
  logic                            o_valid;
  logic                            i_ready;
  logic                            o_frame_err;

  modport slave (
    input  i_coef, i_coef_valid, i_coef_last, i_gain_we, i_gain_addr, i_gain_data, i_ready,
    output o_coef_ready, o_value, o_valid, o_frame_err
  );

  modport master (
    output i_coef, i_coef_valid, i_coef_last, i_gain_we, i_gain_addr, i_gain_data, i_ready,
    input  o_coef_ready, o_value, o_valid, o_frame_err
  );

endinterface

// File: rtl/wavelet_saturate.sv
// rtl/wavelet_saturate.sv - round-half-up, shift and saturate accumulator to sample width
// Purpose: combinational conversion of a Q.(GAIN_BITS-1) accumulator into a signed sample.
// Ports: i_acc (ACC_BITS signed accumulator), o_value (BITS signed saturated sample).
module wavelet_saturate #(
  parameter int ACC_BITS  = 20,
  parameter int BITS      = 8,
  parameter int GAIN_BITS = 8
) (
  input  logic signed [ACC_BITS-1:0] i_acc,
  output logic signed [BITS-1:0]     o_value
);

  localparam int                     SHIFT = GAIN_BITS - 1;
  localparam logic signed [ACC_BITS-1:0] HALF  = ACC_BITS'(2 ** (GAIN_BITS - 2));
  localparam logic signed [ACC_BITS-1:0] MAX_V = ACC_BITS'(2 ** (BITS - 1) - 1);
  // Two's complement: inverting 0..0111 gives 1..1000, the most negative sample.
  localparam logic signed [ACC_BITS-1:0] MIN_V = ~MAX_V;

  logic signed [ACC_BITS-1:0] w_sum;
  logic signed [ACC_BITS-1:0] w_shift;

  // The accumulator carries clog2(NUM_FILTERS) spare bits, so adding HALF cannot wrap.
  assign w_sum   = i_acc + HALF;
  assign w_shift = w_sum >>> SHIFT;

  always_comb begin
    o_value = w_shift[BITS-1:0];
    if (w_shift > MAX_V)      o_value = MAX_V[BITS-1:0];
    else if (w_shift < MIN_V) o_value = MIN_V[BITS-1:0];
  end

endmodule

// File: rtl/wavelet_synthesis.sv
// rtl/wavelet_synthesis.sv - gain-weighted accumulation of a band frame into one sample
// Purpose: FSM, band counter, multiply-accumulate and per-band gain file of the synthesis bank.
// Ports: clk, rst_n (async active-low), io_bus (wavelet_synthesis_if.slave: coefficient
//        stream, gain write port, output sample handshake, framing error pulse).
module wavelet_synthesis
  import wavelet_pkg::*;
#(
  parameter int BITS_PER_ELEM = DEF_BITS_PER_ELEM,
  parameter int NUM_FILTERS   = DEF_NUM_FILTERS,
  parameter int GAIN_BITS     = DEF_GAIN_BITS
) (
  input logic                 clk,
  input logic                 rst_n,
  wavelet_synthesis_if.slave  io_bus
);

  localparam int K_W    = addr_bits(NUM_FILTERS);
  localparam int ACC_W  = acc_bits(BITS_PER_ELEM, GAIN_BITS, NUM_FILTERS);
  localparam int PROD_W = BITS_PER_ELEM + GAIN_BITS + 1;
  localparam logic [K_W-1:0]       K_LAST = K_W'(NUM_FILTERS - 1);
  localparam logic [GAIN_BITS-1:0] UNITY  = GAIN_BITS'(unity_gain(GAIN_BITS));

  state_t                          r_state;
  state_t                          w_state_next;
  logic [K_W-1:0]                  r_k;
  logic signed [ACC_W-1:0]         r_acc;
  logic [GAIN_BITS-1:0]            r_gain [NUM_FILTERS];
  logic signed [BITS_PER_ELEM-1:0] r_value;
  logic                            r_frame_err;

  logic                            w_accept;
  logic                            w_last_band;
  logic                            w_coef_ready;
  logic                            w_valid;
  logic signed [PROD_W-1:0]        w_coef_ext;
  logic signed [PROD_W-1:0]        w_gain_ext;
  logic signed [PROD_W-1:0]        w_prod;
  logic signed [ACC_W-1:0]         w_prod_ext;
  logic signed [ACC_W-1:0]         w_acc_next;
  logic signed [BITS_PER_ELEM-1:0] w_sat;

  assign w_accept    = io_bus.i_coef_valid && (r_state == ACCUM);
  assign w_last_band = (r_k == K_LAST);

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  assign w_coef_ext = {{(GAIN_BITS + 1){io_bus.i_coef[BITS_PER_ELEM-1]}}, io_bus.i_coef};
  assign w_gain_ext = $signed({{(BITS_PER_ELEM + 1){1'b0}}, r_gain[r_k]});
  assign w_prod     = w_coef_ext * w_gain_ext;
  assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
  // Band 0 restarts the sum, so no explicit clear is needed between frames.
  assign w_acc_next = (r_k == '0) ? w_prod_ext : (r_acc + w_prod_ext);

  wavelet_saturate #(
    .ACC_BITS  (ACC_W),
    .BITS      (BITS_PER_ELEM),
    .GAIN_BITS (GAIN_BITS)
  ) u_saturate (
    .i_acc   (w_acc_next),
    .o_value (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_coef_ready = 1'b0;
    w_valid      = 1'b0;
    case (r_state)
      ACCUM: begin
        w_coef_ready = 1'b1;
        if (w_accept && w_last_band) w_state_next = OUTPUT;
      end
      OUTPUT: begin
        w_valid = 1'b1;
        if (io_bus.i_ready) w_state_next = ACCUM;
      end
      default: w_state_next = ACCUM;
    endcase
  end

  // r_value only loads on the final band, which cannot happen in OUTPUT, so it holds during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k         <= '0;
      r_acc       <= '0;
      r_value     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_accept) begin
        if (w_last_band) begin
          r_k         <= '0;
          r_acc       <= w_acc_next;
          r_value     <= w_sat;
          r_frame_err <= !io_bus.i_coef_last;
        end else if (io_bus.i_coef_last) begin
          r_k         <= '0;
          r_frame_err <= 1'b1;
        end else begin
          r_k   <= r_k + K_W'(1);
          r_acc <= w_acc_next;
        end
      end
    end
  end

  // Registered file: a beat in the same cycle as a write still sees the old gain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FILTERS; i++) r_gain[i] <= UNITY;
    end else if (io_bus.i_gain_we && (int'(io_bus.i_gain_addr) < NUM_FILTERS)) begin
      r_gain[io_bus.i_gain_addr] <= io_bus.i_gain_data;
    end
  end

  assign io_bus.o_coef_ready = w_coef_ready;
  assign io_bus.o_valid      = w_valid;
  assign io_bus.o_value      = r_value;
  assign io_bus.o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_wavelet_synthesis.sv
// tb/tb_wavelet_synthesis.sv - scoreboard bench for wavelet_synthesis
module tb_wavelet_synthesis;

  localparam int BPE = 8;
  localparam int NF  = 8;
  localparam int GB  = 8;

  logic clk;
  logic rst_n;

  wavelet_synthesis_if #(.BITS_PER_ELEM(BPE), .NUM_FILTERS(NF), .GAIN_BITS(GB)) bus ();

  wavelet_synthesis #(.BITS_PER_ELEM(BPE), .NUM_FILTERS(NF), .GAIN_BITS(GB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     tests;
  int     fails;
  int     exp_q[$];
  bit     err_q[$];
  int     gain_m[NF];
  int     mk;
  longint msum;
  bit     rand_ready;

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: exact rational sum, rounded half up to the nearest integer, clamped to range.
  function automatic int model_out(input longint acc);
    longint scale;
    longint num;
    longint q;
    scale = longint'(1) << (GB - 1);
    num   = acc + scale / 2;
    if (num >= 0) q = num / scale;
    else          q = -((-num + scale - 1) / scale);
    if (q > (2 ** (BPE - 1)) - 1) q = (2 ** (BPE - 1)) - 1;
    if (q < -(2 ** (BPE - 1)))    q = -(2 ** (BPE - 1));
    return int'(q);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) gain_m[i] = 1 << (GB - 1);
    mk   = 0;
    msum = 0;
    exp_q.delete();
    err_q.delete();
  endtask

  task automatic drive_beat(input int coef, input bit last, input bit gwe, input int gaddr, input int gdata);
    int     n;
    bit     frame_done;
    longint prod;
    n = 0;
    while (!bus.o_coef_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.o_coef_ready) begin
      check("coef_ready_timeout", 0, 1);
      return;
    end
    bus.i_coef       = BPE'(coef);
    bus.i_coef_valid = 1'b1;
    bus.i_coef_last  = last;
    bus.i_gain_we    = gwe;
    bus.i_gain_addr  = 3'(gaddr);
    bus.i_gain_data  = GB'(gdata);
    prod = longint'(coef) * longint'(gain_m[mk]);
    msum = (mk == 0) ? prod : msum + prod;
    frame_done = 1'b0;
    if (mk == NF - 1) begin
      exp_q.push_back(model_out(msum));
      err_q.push_back(!last);
      mk = 0;
      frame_done = 1'b1;
    end else if (last) begin
      err_q.push_back(1'b1);
      mk = 0;
    end else begin
      err_q.push_back(1'b0);
      mk++;
    end
    if (gwe) gain_m[gaddr] = gdata;
    @(posedge clk); #1;
    bus.i_coef_valid = 1'b0;
    bus.i_coef_last  = 1'b0;
    bus.i_gain_we    = 1'b0;
    if (frame_done) check("valid_latency", int'(bus.o_valid), 1);
  endtask

  task automatic write_gain(input int addr, input int data);
    bus.i_gain_we   = 1'b1;
    bus.i_gain_addr = 3'(addr);
    bus.i_gain_data = GB'(data);
    @(posedge clk); #1;
    bus.i_gain_we = 1'b0;
    gain_m[addr] = data;
  endtask

  // last_at: NF-1 normal, < NF-1 early last (frame cut short), >= NF no last at all.
  task automatic send_frame(input int c[NF], input int last_at);
    int nb;
    nb = (last_at < NF) ? last_at + 1 : NF;
    for (int i = 0; i < nb; i++) drive_beat(c[i], (i == last_at), 1'b0, 0, 0);
  endtask

  task automatic send_const(input int v);
    int c[NF];
    for (int i = 0; i < NF; i++) c[i] = v;
    send_frame(c, NF - 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  // Random backpressure, active only while rand_ready is set.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) bus.i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: frame_err every cycle, output value on every valid cycle, pop on handshake.
  initial begin
    bit beat_pending;
    int exp_e;
    beat_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        beat_pending = 1'b0;
        continue;
      end
      exp_e = 0;
      if (beat_pending) begin
        if (err_q.size() != 0) exp_e = int'(err_q.pop_front());
      end
      check("frame_err", int'(bus.o_frame_err), exp_e);
      if (bus.o_valid) begin
        check("ready_low_in_output", int'(bus.o_coef_ready), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", int'(bus.o_valid), 0);
        end else begin
          check("o_value", int'(bus.o_value), exp_q[0]);
          if (bus.i_ready) void'(exp_q.pop_front());
        end
      end
      beat_pending = bus.i_coef_valid && bus.o_coef_ready;
    end
  end

  initial begin
    int c[NF];
    int last_at;
    int sel;
    tests = 0;
    fails = 0;
    rand_ready       = 1'b0;
    rst_n            = 1'b0;
    bus.i_coef       = '0;
    bus.i_coef_valid = 1'b0;
    bus.i_coef_last  = 1'b0;
    bus.i_gain_we    = 1'b0;
    bus.i_gain_addr  = '0;
    bus.i_gain_data  = '0;
    bus.i_ready      = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", int'(bus.o_valid), 0);
    check("reset_coef_ready", int'(bus.o_coef_ready), 1);
    check("reset_value", int'(bus.o_value), 0);
    check("reset_frame_err", int'(bus.o_frame_err), 0);
    rst_n = 1'b1;

    send_const(1);
    wait_drain();
    send_const(127);
    send_const(-128);
    wait_drain();

    for (int a = 0; a < NF; a++) write_gain(a, (a == 3) ? 8'h40 : 0);
    for (int i = 0; i < NF; i++) c[i] = (i == 3) ? 10 : 100;
    send_frame(c, NF - 1);
    wait_drain();
    for (int a = 0; a < NF; a++) write_gain(a, 1 << (GB - 1));

    bus.i_ready = 1'b0;
    send_const(3);
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_coef_ready", int'(bus.o_coef_ready), 0);
      check("stall_valid", int'(bus.o_valid), 1);
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    check("post_handshake_ready", int'(bus.o_coef_ready), 1);
    check("post_handshake_valid", int'(bus.o_valid), 0);
    send_const(5);
    wait_drain();

    for (int i = 0; i < NF; i++) c[i] = 7;
    send_frame(c, 3);
    send_const(2);
    for (int i = 0; i < NF; i++) c[i] = 4;
    send_frame(c, NF);
    wait_drain();

    write_gain(0, 0);
    for (int i = 0; i < 4; i++) drive_beat(9, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      check("mid_reset_valid", int'(bus.o_valid), 0);
      check("mid_reset_coef_ready", int'(bus.o_coef_ready), 1);
    end
    rst_n = 1'b1;
    send_const(1);
    wait_drain();

    rand_ready = 1'b1;
    for (int f = 0; f < 30; f++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      last_at = $urandom_range(0, NF - 2);
      else if (sel == 1) last_at = NF;
      else               last_at = NF - 1;
      for (int i = 0; i < NF; i++) begin
        if (i > last_at) break;
        if ($urandom_range(0, 4) == 0)
          drive_beat($urandom_range(0, 255) - 128, (i == last_at), 1'b1,
                     $urandom_range(0, NF - 1), $urandom_range(0, 255));
        else
          drive_beat($urandom_range(0, 255) - 128, (i == last_at), 1'b0, 0, 0);
      end
    end
    @(posedge clk); #1;
    rand_ready  = 1'b0;
    bus.i_ready = 1'b1;
    wait_drain();
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
